// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, byte type and default busy timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } arb_state_t;

    typedef logic [7:0] uart_byte_t;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first asserted request after the last grant,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_last,
    output logic [2:0]       o_idx,
    output logic             o_valid
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (i_req[k] && (k == (int'(i_last) + i) % N_REQ)) begin
                    o_idx   = 3'(k);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among N_REQ byte requesters with
// round-robin arbitration, message locking and a busy timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ-1:0]   lock_i,
    input  logic [8*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    output logic [2:0]         grant_o,
    output logic               err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    logic [2:0]       r_grant;
    logic [2:0]       r_last;
    uart_byte_t       r_data;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_pick_idx;
    logic             w_pick_valid;
    uart_byte_t       w_pick_byte;
    uart_byte_t       w_grant_byte;
    logic             w_grant_req;
    logic             w_grant_lock;
    logic             w_launch;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (req_i),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_launch = (r_state == S_LAUNCH);

    always_comb begin
        w_pick_byte  = '0;
        w_grant_byte = '0;
        w_grant_req  = 1'b0;
        w_grant_lock = 1'b0;
        ack_o        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (3'(k) == w_pick_idx) begin
                w_pick_byte = data_i[8*k +: 8];
            end
            if (3'(k) == r_grant) begin
                w_grant_byte = data_i[8*k +: 8];
                w_grant_req  = req_i[k];
                w_grant_lock = lock_i[k];
                ack_o[k]     = w_launch;
            end
        end
    end

    // The byte is captured on entry to LAUNCH so tx_data_o holds afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 3'(N_REQ - 1);
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_data  <= w_pick_byte;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_last  <= r_grant;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (w_grant_lock && w_grant_req) begin
                            r_data  <= w_grant_byte;
                            r_state <= S_LAUNCH;
                        end else begin
                            r_last  <= r_grant;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_start_o = w_launch;
    assign tx_data_o  = r_data;
    assign grant_o    = r_grant;
    assign err_o      = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table, contention,
// lock, timeout and mid-transfer reset sequences with a scoreboard.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  req  = '0;
    logic [3:0]  lock = '0;
    logic [31:0] data = '0;
    logic        busy = 1'b0;
    logic [3:0]  ack;
    logic        start;
    logic [7:0]  txd;
    logic [2:0]  grant;
    logic        err;

    uart_tx_arb #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .lock_i     (lock),
        .data_i     (data),
        .ack_o      (ack),
        .tx_start_o (start),
        .tx_data_o  (txd),
        .tx_busy_i  (busy),
        .grant_o    (grant),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [2:0]  g;
        logic [7:0]  d;
        int          blen;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic expire(string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Transmitter model: busy rises 2 cycles after start, lasts m_len cycles.
    bit m_en  = 1'b1;
    int m_len = 20;
    int m_dly = 0;
    int m_left = 0;

    always @(posedge clk) begin
        if (rst || !m_en) begin
            m_dly  <= 0;
            m_left <= 0;
            busy   <= 1'b0;
        end else if (start) begin
            m_dly <= 2;
            busy  <= 1'b0;
        end else if (m_dly != 0) begin
            m_dly <= m_dly - 1;
            if (m_dly == 1) begin
                busy   <= 1'b1;
                m_left <= m_len;
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && (start || ack != '0)) begin
            if (!start) begin
                chk("ack_outside_launch", 32'(ack), 32'd0);
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_start: data %0h grant %0d, want none",
                         txd, grant);
            end else begin
                m_e = sb.pop_front();
                chk("grant", 32'(grant), 32'(m_e.g));
                chk("tx_data", 32'(txd), 32'(m_e.d));
                chk("ack_onehot", 32'(ack), 32'(4'b0001 << m_e.g));
            end
        end
    end

    task automatic check_reset(string nm);
        chk({nm, "_ack"}, 32'(ack), 32'd0);
        chk({nm, "_start"}, 32'(start), 32'd0);
        chk({nm, "_txd"}, 32'(txd), 32'd0);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset(int cyc);
        rst = 1'b1;
        repeat (cyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (start) got = 1'b1;
        end
        if (!got) begin
            expire("wait_start");
            cyc = -1;
        end
    endtask

    task automatic wait_busy_rise();
        int c;
        c = 0;
        while (!busy && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!busy) expire("busy_rise");
    endtask

    task automatic wait_tx_done();
        int c;
        wait_busy_rise();
        c = 0;
        while (busy && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (busy) expire("busy_fall");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int k;
        logic [7:0] b[4];

        tbl[0] = '{4'b0001, 32'h0000_0043, 3'd0, 8'h43, 400};
        tbl[1] = '{4'b0110, 32'h00A2_A100, 3'd1, 8'hA1, 20};
        tbl[2] = '{4'b0011, 32'h0000_B1B0, 3'd0, 8'hB0, 20};
        tbl[3] = '{4'b1000, 32'hC300_0000, 3'd3, 8'hC3, 20};
        tbl[4] = '{4'b1001, 32'hD300_00D0, 3'd0, 8'hD0, 20};
        tbl[5] = '{4'b1110, 32'hE3E2_E100, 3'd1, 8'hE1, 20};
        b = '{8'h62, 8'h61, 8'h6A, 8'h73};

        do_reset(3);
        check_reset("por");

        for (int i = 0; i < 6; i++) begin
            m_len = tbl[i].blen;
            data  = tbl[i].data;
            req   = tbl[i].req;
            sb.push_back('{tbl[i].g, tbl[i].d});
            wait_start(c);
            chk($sformatf("latency_vec%0d", i), 32'(c), 32'd1);
            req = '0;
            wait_tx_done();
        end

        do_reset(2);
        m_len = 20;
        data  = 32'h1312_1110;
        req   = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                sb.push_back('{3'(j), 8'(8'h10 + j)});
            end
        end
        for (int j = 0; j < 8; j++) begin
            wait_start(c);
            if (j == 0) chk("latency_contention", 32'(c), 32'd1);
        end
        req = '0;
        wait_tx_done();

        do_reset(1);
        data = {8'h00, b[0], 8'h51, 8'h00};
        req  = 4'b0100;
        lock = 4'b0100;
        sb.push_back('{3'd2, b[0]});
        wait_start(c);
        req[1] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            data[23:16] = b[i];
            sb.push_back('{3'd2, b[i]});
            wait_start(c);
        end
        req[2]  = 1'b0;
        lock[2] = 1'b0;
        sb.push_back('{3'd1, 8'h51});
        wait_start(c);
        req = '0;
        wait_tx_done();

        m_en = 1'b0;
        data[31:24] = 8'h33;
        req = 4'b1000;
        sb.push_back('{3'd3, 8'h33});
        wait_start(c);
        req = '0;
        k = 0;
        while (!err && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("err_latency", 32'(k), 32'(TO + 1));
        m_en = 1'b1;
        data[7:0] = 8'h0A;
        req = 4'b0001;
        sb.push_back('{3'd0, 8'h0A});
        wait_start(c);
        chk("latency_after_timeout", 32'(c), 32'd1);
        req = '0;
        wait_tx_done();
        chk("err_sticky", 32'(err), 32'd1);

        data[23:16] = 8'h77;
        req = 4'b0100;
        sb.push_back('{3'd2, 8'h77});
        wait_start(c);
        req = '0;
        wait_busy_rise();
        @(posedge clk);
        #1;
        do_reset(1);
        check_reset("midrst");
        data[15:8] = 8'h21;
        req = 4'b0010;
        sb.push_back('{3'd1, 8'h21});
        wait_start(c);
        chk("latency_after_reset", 32'(c), 32'd1);
        req = '0;
        wait_tx_done();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for tx_busy_i to rise after a start pulse.
REQ-003 clk_i  input  1  single system clock (40 MHz); all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  N_REQ  per-requester byte-valid; held high until the matching ack_o.
REQ-006 lock_i  input  N_REQ  per-requester message lock; high keeps the grant across consecutive bytes.
REQ-007 data_i  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]; stable while req_i[k] is high.
REQ-008 ack_o  output  N_REQ  one-cycle pulse; the byte of requester k is consumed.
REQ-009 tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data_o  output  8  byte to the transmitter; valid while tx_start_o is high.
REQ-011 tx_busy_i  input  1  transmitter busy, high from shortly after start until the stop bit ends.
REQ-012 grant_o  output  3  index of the current or last granted requester.
REQ-013 err_o  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any req_i bit is high, select the first high bit searching from last_grant+1 upward modulo N_REQ, register it in grant_o, and go to LAUNCH.
REQ-016 LAUNCH: for exactly one cycle, drive tx_start_o=1, tx_data_o=data_i[grant], and ack_o[grant]=1, then go to WAIT_BUSY.
REQ-017 Latency: req_i rising in IDLE at cycle n gives tx_start_o and ack_o at cycle n+1.
REQ-018 WAIT_BUSY: go to WAIT_DONE on the first cycle tx_busy_i=1; a counter counts cycles in this state.
REQ-019 If the counter reaches TIMEOUT without tx_busy_i, set err_o, update last_grant, and return to IDLE; the byte is dropped and already acked.
REQ-020 WAIT_DONE: on tx_busy_i=0, if lock_i[grant] and req_i[grant] are both high, go to LAUNCH with the same grant; otherwise set last_grant=grant and go to IDLE.
REQ-021 If lock_i[grant] is high but req_i[grant] is low when tx_busy_i falls, release the lock: go to IDLE.
REQ-022 While locked, requests from other requesters are ignored; no interleaving within a message.
REQ-023 At most one ack_o bit is high in any cycle; ack_o is never high outside LAUNCH.
REQ-024 tx_data_o holds its last value outside LAUNCH; tx_start_o is 0 outside LAUNCH.
REQ-025 A req_i bit that drops before its ack is ignored; the arbiter does not abort a LAUNCH already taken.
REQ-026 Simultaneous requests: round-robin guarantees each requester a grant within N_REQ unlocked grants.
REQ-027 Timeout counter width is clog2(TIMEOUT+1); it is cleared on entry to WAIT_BUSY.

Reset
REQ-028 Reset takes priority over all other inputs, in any state and mid-transfer.
REQ-029 Reset values: state=IDLE, ack_o=0, tx_start_o=0, tx_data_o=8'h00, grant_o=0, last_grant=N_REQ-1 (so requester 0 wins first), err_o=0, counter=0.
REQ-030 A reset during WAIT_DONE does not wait for tx_busy_i; the first grant after reset starts from IDLE.

Structure
REQ-031 A shared package uart_pkg holds the state enum type, the byte type, and the default TIMEOUT constant.
REQ-032 The round-robin next-index search is a separate combinational sub-module rr_pick (inputs: request vector, last grant; outputs: index and valid).
REQ-033 The block instantiates no UART; the lab0 transmitter attaches at the tx_* ports.

Verification
REQ-034 Single request: req_i=4'b0001, data 8'h43, transmitter model raises busy 2 cycles after start for 400 cycles -> one tx_start_o with tx_data_o=8'h43, ack_o[0] one cycle later than req, grant_o=0.
REQ-035 Contention: req_i=4'b1111 held with data 8'h10/11/12/13 -> start order 8'h10, 8'h11, 8'h12, 8'h13, repeating; no two acks in the same cycle.
REQ-036 Lock: requester 2 sends 4 bytes 8'h62,8'h61,8'h6A,8'h73 with lock_i[2]=1 while req_i[1]=1 -> all 4 bytes are sent back-to-back, then requester 1 is granted.
REQ-037 Timeout: tx_busy_i held 0 with req_i[3]=1 -> err_o rises at TIMEOUT+1 cycles after start, FSM returns to IDLE, and the next request is served.
REQ-038 Reset mid-transfer: assert rst_i one cycle in WAIT_DONE -> all outputs reach their reset values next cycle, and a following req_i[1] is granted from IDLE.
REQ-039 Loopback: the arbiter drives the lab0 UART with tx looped to rx -> led_o shows each transmitted byte in grant order.
